otus_hist_scan: RTL and testbench

OTUS_HIST_SCAN -- requirements
Module: otus_hist_scan

---
 rtl/otus_pkg.sv | 26 ++
 rtl/otus_bin_acc.sv | 40 ++++
 rtl/otus_hist_scan.sv | 177 +++++++++++++++++
 tb/tb_otus_hist_scan.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otus_pkg.sv
// Shared definitions for the Otsu histogram scanner and its DSP consumer.
// Holds the histogram geometry, the data-path widths, the scanner state
// enumeration and a helper that extracts the published gray-sum bits.
package otus_pkg;

  localparam int BIN_NUM   = 128;  // gray bins in the histogram RAM
  localparam int SLOT_LEN  = 8;    // clocks per threshold slot
  localparam int ADDR_W    = 7;    // bin address / gray value width
  localparam int CNT_W     = 20;   // pixel count width
  localparam int GSUM_W    = 27;   // sum of count*gray width
  localparam int OUT_W     = 23;   // published gray-sum width (bits [26:4])
  localparam int TAIL_IDLE = 7;    // idle clocks after the last dsp_vld

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TOTAL = 2'd1,
    SWEEP = 2'd2,
    CLEAR = 2'd3
  } otus_state_e;

  // Drop the four fractional LSBs of a gray sum.
  function automatic logic [OUT_W-1:0] gsum_out(input logic [GSUM_W-1:0] g);
    return g[GSUM_W-1:GSUM_W-OUT_W];
  endfunction

endpackage

// File: rtl/otus_bin_acc.sv
// Count / gray-sum accumulator pair.
// Ports:
//   clock, rst_n : clock and asynchronous active-low reset
//   clr          : synchronous clear of both accumulators (wins over add_en)
//   add_en       : add cnt_in to n_acc and cnt_in*gray_in to g_acc
//   cnt_in       : bin pixel count
//   gray_in      : bin gray value (its address)
//   n_acc, g_acc : running count sum and gray-weighted sum, modulo width
module otus_bin_acc
  import otus_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [ADDR_W-1:0] gray_in,
  output logic [CNT_W-1:0]  n_acc,
  output logic [GSUM_W-1:0] g_acc
);

  logic [GSUM_W-1:0] prod;

  // 20x7 product always fits in 27 bits.
  assign prod = GSUM_W'(cnt_in) * GSUM_W'(gray_in);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n_acc <= '0;
      g_acc <= '0;
    end else if (clr) begin
      n_acc <= '0;
      g_acc <= '0;
    end else if (add_en) begin
      n_acc <= n_acc + cnt_in;
      g_acc <= g_acc + prod;
    end
  end

endmodule

// File: rtl/otus_hist_scan.sv
// Otsu histogram scanner.
// After a start pulse it totals the histogram (TOTAL), then sweeps all 128
// thresholds publishing class-1 / class-2 counts and gray sums with one
// dsp_vld strobe per SLOT_LEN-clock slot (SWEEP), then zeroes the RAM
// (CLEAR) for the next frame.
// Ports:
//   clock, rst_n              : clock, asynchronous active-low reset
//   start                     : end-of-frame pulse, ignored unless IDLE
//   ram_rd_addr / ram_rd_data : histogram read port, 1-clock latency
//   ram_wr_en/addr/data       : histogram write port (zero writes only)
//   dsp_vld                   : strobe qualifying the four data outputs
//   N1_u20, N2_u20            : pixel counts in bins 0..t and t+1..127
//   GrayAll1, GrayAll2        : count*gray sums of the same ranges, [26:4]
//   finish_clear              : pulse with the final RAM zero-write
//   busy                      : frame in progress
module otus_hist_scan #(
  parameter int BIN_NUM  = otus_pkg::BIN_NUM,
  parameter int SLOT_LEN = otus_pkg::SLOT_LEN
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [otus_pkg::ADDR_W-1:0]  ram_rd_addr,
  input  logic [otus_pkg::CNT_W-1:0]   ram_rd_data,
  output logic                         ram_wr_en,
  output logic [otus_pkg::ADDR_W-1:0]  ram_wr_addr,
  output logic [otus_pkg::CNT_W-1:0]   ram_wr_data,
  output logic                         dsp_vld,
  output logic [otus_pkg::CNT_W-1:0]   N1_u20,
  output logic [otus_pkg::CNT_W-1:0]   N2_u20,
  output logic [otus_pkg::OUT_W-1:0]   GrayAll1,
  output logic [otus_pkg::OUT_W-1:0]   GrayAll2,
  output logic                         finish_clear,
  output logic                         busy
);
  import otus_pkg::*;

  // Slot clock roles: address at 0, data captured at 1, accumulated at 2,
  // outputs registered at 3 (visible with dsp_vld on 4).
  localparam logic [7:0] SC_CAPT     = 8'd1;
  localparam logic [7:0] SC_ADD      = 8'd2;
  localparam logic [7:0] SC_OUT      = 8'd3;
  localparam logic [7:0] SC_SLOT_END = 8'(SLOT_LEN - 1);
  // The last slot stretches so that TAIL_IDLE clocks follow its dsp_vld.
  localparam logic [7:0] SC_TAIL_END = 8'(SC_OUT + 1 + TAIL_IDLE);

  otus_state_e state_reg, state_next;

  logic [7:0]        idx_reg;      // TOTAL read address / CLEAR write address
  logic [ADDR_W-1:0] t_reg;        // current threshold
  logic [7:0]        sc_reg;       // clock within the current slot
  logic              rd_pend_reg;  // a TOTAL read was issued last clock
  logic [CNT_W-1:0]  bin_reg;      // bin t captured from the read port

  logic              acc_clr, tot_add, c1_add, last_slot;
  logic [ADDR_W-1:0] tot_gray;
  logic [CNT_W-1:0]  nt, n1;
  logic [GSUM_W-1:0] gt, g1, g2_diff;

  assign last_slot = (t_reg == ADDR_W'(BIN_NUM - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = TOTAL;
      TOTAL:   if (idx_reg == 8'(BIN_NUM)) state_next = SWEEP;
      SWEEP:   if (last_slot && sc_reg == SC_TAIL_END) state_next = CLEAR;
      CLEAR:   if (idx_reg == 8'(BIN_NUM - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      t_reg       <= '0;
      sc_reg      <= '0;
      rd_pend_reg <= 1'b0;
      bin_reg     <= '0;
    end else begin
      rd_pend_reg <= (state_reg == TOTAL) && (idx_reg < 8'(BIN_NUM));
      case (state_reg)
        IDLE: begin
          idx_reg <= '0;
          t_reg   <= '0;
          sc_reg  <= '0;
        end
        TOTAL: begin
          // One extra clock past the last address lets bin 127 land.
          if (state_next == SWEEP) idx_reg <= '0;
          else                     idx_reg <= idx_reg + 8'd1;
        end
        SWEEP: begin
          if (sc_reg == SC_CAPT) bin_reg <= ram_rd_data;
          if (!last_slot && sc_reg == SC_SLOT_END) begin
            sc_reg <= '0;
            t_reg  <= t_reg + 7'd1;
          end else begin
            sc_reg <= sc_reg + 8'd1;
          end
        end
        CLEAR: idx_reg <= idx_reg + 8'd1;
        default: idx_reg <= '0;
      endcase
    end
  end

  assign acc_clr  = (state_reg == IDLE) && start;
  assign tot_add  = (state_reg == TOTAL) && rd_pend_reg;
  // Data arriving now belongs to the address issued one clock ago.
  assign tot_gray = idx_reg[ADDR_W-1:0] - 7'd1;
  assign c1_add   = (state_reg == SWEEP) && (sc_reg == SC_ADD);

  otus_bin_acc u_total (
    .clock   (clock),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .add_en  (tot_add),
    .cnt_in  (ram_rd_data),
    .gray_in (tot_gray),
    .n_acc   (nt),
    .g_acc   (gt)
  );

  otus_bin_acc u_class1 (
    .clock   (clock),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .add_en  (c1_add),
    .cnt_in  (bin_reg),
    .gray_in (t_reg),
    .n_acc   (n1),
    .g_acc   (g1)
  );

  assign g2_diff = gt - g1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dsp_vld  <= 1'b0;
      N1_u20   <= '0;
      N2_u20   <= '0;
      GrayAll1 <= '0;
      GrayAll2 <= '0;
    end else begin
      dsp_vld <= 1'b0;
      if (state_reg == SWEEP && sc_reg == SC_OUT) begin
        dsp_vld  <= 1'b1;
        N1_u20   <= n1;
        N2_u20   <= nt - n1;
        GrayAll1 <= gsum_out(g1);
        GrayAll2 <= gsum_out(g2_diff);
      end
    end
  end

  always_comb begin
    ram_rd_addr = '0;
    case (state_reg)
      TOTAL:   ram_rd_addr = idx_reg[ADDR_W-1:0];
      SWEEP:   ram_rd_addr = t_reg;
      default: ram_rd_addr = '0;
    endcase
  end

  assign ram_wr_en    = (state_reg == CLEAR);
  assign ram_wr_addr  = idx_reg[ADDR_W-1:0];
  assign ram_wr_data  = '0;
  assign finish_clear = (state_reg == CLEAR) && (idx_reg == 8'(BIN_NUM - 1));
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_otus_hist_scan.sv
// Directed testbench for otus_hist_scan with a behavioural histogram RAM.
module tb_otus_hist_scan;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  ram_rd_addr, ram_wr_addr;
  logic [19:0] ram_rd_data, ram_wr_data;
  logic        ram_wr_en, dsp_vld, finish_clear, busy;
  logic [19:0] N1_u20, N2_u20;
  logic [22:0] GrayAll1, GrayAll2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  otus_hist_scan dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .dsp_vld      (dsp_vld),
    .N1_u20       (N1_u20),
    .N2_u20       (N2_u20),
    .GrayAll1     (GrayAll1),
    .GrayAll2     (GrayAll2),
    .finish_clear (finish_clear),
    .busy         (busy)
  );

  // Histogram RAM: registered read, bench load port has priority.
  logic [19:0] mem [128];
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [19:0] ld_data = '0;

  always @(posedge clock) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (ld_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
  end

  // Monitor: cycle counter plus per-frame capture of every dsp_vld.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        mon_clr = 1'b0;
  int          vld_cnt = 0, fc_cnt = 0, fc_cyc = 0, wr_cnt = 0, hold_viol = 0;
  int          dsp_cyc [128];
  logic [19:0] cap_n1 [128], cap_n2 [128];
  logic [22:0] cap_g1 [128], cap_g2 [128];
  logic        busy_at_fc = 1'b0, busy_after_fc = 1'b0, fc_prev = 1'b0;
  logic [19:0] last_n1 = '0, last_n2 = '0;
  logic [22:0] last_g1 = '0, last_g2 = '0;

  always @(negedge clock) begin
    if (mon_clr) begin
      vld_cnt = 0; fc_cnt = 0; fc_cyc = 0; wr_cnt = 0; hold_viol = 0;
      for (int i = 0; i < 128; i++) begin
        dsp_cyc[i] = 0; cap_n1[i] = '0; cap_n2[i] = '0; cap_g1[i] = '0; cap_g2[i] = '0;
      end
    end
    if (!rst_n) begin
      last_n1 = '0; last_n2 = '0; last_g1 = '0; last_g2 = '0; fc_prev = 1'b0;
    end else begin
      if (dsp_vld) begin
        if (vld_cnt < 128) begin
          dsp_cyc[vld_cnt] = cyc;
          cap_n1[vld_cnt] = N1_u20; cap_n2[vld_cnt] = N2_u20;
          cap_g1[vld_cnt] = GrayAll1; cap_g2[vld_cnt] = GrayAll2;
        end
        vld_cnt++;
        last_n1 = N1_u20; last_n2 = N2_u20; last_g1 = GrayAll1; last_g2 = GrayAll2;
      end else if (N1_u20 !== last_n1 || N2_u20 !== last_n2 ||
                   GrayAll1 !== last_g1 || GrayAll2 !== last_g2) begin
        hold_viol++;
      end
      if (fc_prev) begin
        busy_after_fc = busy;
        fc_prev = 1'b0;
      end
      if (finish_clear) begin
        fc_cnt++; fc_cyc = cyc; busy_at_fc = busy; fc_prev = 1'b1;
      end
      if (ram_wr_en) wr_cnt++;
    end
  end

  int start_cyc = 0;

  task automatic load_bin(input int a, input int d);
    ld_addr = 7'(a); ld_data = 20'(d); ld_en = 1'b1;
    @(posedge clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic ram_clear();
    ld_clr = 1'b1;
    @(posedge clock); #1;
    ld_clr = 1'b0;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clock); #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_pulse();
    @(posedge clock); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_fc();
    int n;
    n = 0;
    while (fc_cnt < 1 && n < 4000) begin
      @(posedge clock); n++;
    end
    tests++;
    if (fc_cnt < 1) begin
      fails++;
      $display("FAIL wait_finish_clear: no finish_clear within %0d clocks, required one", n);
    end
    repeat (3) @(posedge clock);
    #1;
    $display("[TB] frame: start@%0d pulses=%0d finish_clear=%0d", start_cyc, vld_cnt, fc_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (dsp_vld !== 1'b0 || finish_clear !== 1'b0 || busy !== 1'b0 || ram_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: dsp_vld=%b finish_clear=%b busy=%b ram_wr_en=%b, required all 0",
               dsp_vld, finish_clear, busy, ram_wr_en);
    end
    tests++;
    if (ram_rd_addr !== 7'd0) begin
      fails++;
      $display("FAIL reset_rd_addr: got %0d, required 0", ram_rd_addr);
    end
    tests++;
    if (N1_u20 !== 20'd0 || N2_u20 !== 20'd0 || GrayAll1 !== 23'd0 || GrayAll2 !== 23'd0) begin
      fails++;
      $display("FAIL reset_data: N1=%0d N2=%0d G1=%0d G2=%0d, required all 0",
               N1_u20, N2_u20, GrayAll1, GrayAll2);
    end
    ram_clear();
    rst_n = 1'b1;
    @(posedge clock); #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_all_zero();
    int nz, gap;
    ram_clear();
    mon_clear();
    start_pulse();
    wait_fc();
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL zero_pulse_count: got %0d, required 128", vld_cnt);
    end
    tests++;
    if (fc_cnt !== 1) begin
      fails++; $display("FAIL zero_fc_count: got %0d, required 1", fc_cnt);
    end
    tests++;
    if (dsp_cyc[0] - start_cyc !== 134) begin
      fails++; $display("FAIL zero_latency: got %0d, required 134", dsp_cyc[0] - start_cyc);
    end
    for (int t = 0; t < 128; t++) begin
      tests++;
      if (cap_n1[t] !== 20'd0 || cap_n2[t] !== 20'd0 || cap_g1[t] !== 23'd0 || cap_g2[t] !== 23'd0) begin
        fails++;
        $display("FAIL zero_data_t%0d: N1=%0d N2=%0d G1=%0d G2=%0d, required all 0",
                 t, cap_n1[t], cap_n2[t], cap_g1[t], cap_g2[t]);
      end
    end
    for (int i = 1; i < 128; i++) begin
      tests++;
      if (dsp_cyc[i] - dsp_cyc[i-1] !== 8) begin
        fails++;
        $display("FAIL zero_spacing_%0d: got %0d clocks, required 8", i, dsp_cyc[i] - dsp_cyc[i-1]);
      end
    end
    gap = fc_cyc - dsp_cyc[127];
    tests++;
    if (gap < 7) begin
      fails++; $display("FAIL zero_fc_gap: got %0d clocks, required >= 7", gap);
    end
    tests++;
    if (wr_cnt !== 128) begin
      fails++; $display("FAIL zero_wr_count: got %0d write clocks, required 128", wr_cnt);
    end
    tests++;
    if (busy_at_fc !== 1'b1 || busy_after_fc !== 1'b0) begin
      fails++;
      $display("FAIL zero_busy_fc: busy at fc=%b after=%b, required 1 then 0", busy_at_fc, busy_after_fc);
    end
    tests++;
    if (hold_viol !== 0) begin
      fails++; $display("FAIL zero_hold: %0d output changes without dsp_vld, required 0", hold_viol);
    end
    nz = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== 20'd0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL zero_ram_clear: %0d nonzero bins, required 0", nz);
    end
  endtask

  task automatic test_bin64();
    int e1, e2, f1, f2;
    ram_clear();
    load_bin(64, 1000);
    mon_clear();
    start_pulse();
    wait_fc();
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL bin64_pulse_count: got %0d, required 128", vld_cnt);
    end
    for (int t = 0; t < 128; t++) begin
      e1 = (t >= 64) ? 1000 : 0;
      e2 = (t >= 64) ? 0 : 1000;
      f1 = (t >= 64) ? 4000 : 0;
      f2 = (t >= 64) ? 0 : 4000;
      tests++;
      if (cap_n1[t] !== 20'(e1) || cap_n2[t] !== 20'(e2) || cap_g1[t] !== 23'(f1) || cap_g2[t] !== 23'(f2)) begin
        fails++;
        $display("FAIL bin64_t%0d: got N1=%0d N2=%0d G1=%0d G2=%0d, required N1=%0d N2=%0d G1=%0d G2=%0d",
                 t, cap_n1[t], cap_n2[t], cap_g1[t], cap_g2[t], e1, e2, f1, f2);
      end
    end
    tests++;
    if (mem[64] !== 20'd0) begin
      fails++; $display("FAIL bin64_ram_clear: bin 64 = %0d, required 0", mem[64]);
    end
  endtask

  task automatic test_two_bins();
    int e1, e2, f1, f2;
    ram_clear();
    load_bin(10, 16);
    load_bin(100, 32);
    mon_clear();
    start_pulse();
    wait_fc();
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL two_pulse_count: got %0d, required 128", vld_cnt);
    end
    tests++;
    if (dsp_cyc[0] - start_cyc !== 134) begin
      fails++; $display("FAIL two_latency: got %0d, required 134", dsp_cyc[0] - start_cyc);
    end
    tests++;
    if (cap_n1[50] !== 20'd16 || cap_n2[50] !== 20'd32 || cap_g1[50] !== 23'd10 || cap_g2[50] !== 23'd200) begin
      fails++;
      $display("FAIL two_t50: got N1=%0d N2=%0d G1=%0d G2=%0d, required 16 32 10 200",
               cap_n1[50], cap_n2[50], cap_g1[50], cap_g2[50]);
    end
    // Totals: 48 pixels, gray sum 160 + 3200 = 3360 (>>4 = 210).
    for (int t = 0; t < 128; t++) begin
      if (t < 10)       begin e1 = 0;  e2 = 48; f1 = 0;   f2 = 210; end
      else if (t < 100) begin e1 = 16; e2 = 32; f1 = 10;  f2 = 200; end
      else              begin e1 = 48; e2 = 0;  f1 = 210; f2 = 0;   end
      tests++;
      if (cap_n1[t] !== 20'(e1) || cap_n2[t] !== 20'(e2) || cap_g1[t] !== 23'(f1) || cap_g2[t] !== 23'(f2)) begin
        fails++;
        $display("FAIL two_t%0d: got N1=%0d N2=%0d G1=%0d G2=%0d, required N1=%0d N2=%0d G1=%0d G2=%0d",
                 t, cap_n1[t], cap_n2[t], cap_g1[t], cap_g2[t], e1, e2, f1, f2);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    ram_clear();
    load_bin(5, 7);
    mon_clear();
    start_pulse();
    n = 0;
    while (vld_cnt < 5 && n < 2000) begin
      @(posedge clock); n++;
    end
    #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL ign_busy_mid: got %b, required 1", busy);
    end
    wait_fc();
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL ign_pulse_count: got %0d, required 128", vld_cnt);
    end
    tests++;
    if (dsp_cyc[0] - start_cyc !== 134) begin
      fails++; $display("FAIL ign_latency: got %0d, required 134", dsp_cyc[0] - start_cyc);
    end
    tests++;
    if (dsp_cyc[127] - dsp_cyc[0] !== 127 * 8) begin
      fails++; $display("FAIL ign_span: got %0d clocks, required %0d", dsp_cyc[127] - dsp_cyc[0], 127 * 8);
    end
    tests++;
    if (busy_at_fc !== 1'b1 || busy_after_fc !== 1'b0) begin
      fails++;
      $display("FAIL ign_busy_fc: busy at fc=%b after=%b, required 1 then 0", busy_at_fc, busy_after_fc);
    end
    // Bin 5 = 7: gray sum 35 (>>4 = 2).
    tests++;
    if (cap_n1[4] !== 20'd0 || cap_n2[4] !== 20'd7 || cap_g1[4] !== 23'd0 || cap_g2[4] !== 23'd2) begin
      fails++;
      $display("FAIL ign_t4: got N1=%0d N2=%0d G1=%0d G2=%0d, required 0 7 0 2",
               cap_n1[4], cap_n2[4], cap_g1[4], cap_g2[4]);
    end
    tests++;
    if (cap_n1[5] !== 20'd7 || cap_n2[5] !== 20'd0 || cap_g1[5] !== 23'd2 || cap_g2[5] !== 23'd0) begin
      fails++;
      $display("FAIL ign_t5: got N1=%0d N2=%0d G1=%0d G2=%0d, required 7 0 2 0",
               cap_n1[5], cap_n2[5], cap_g1[5], cap_g2[5]);
    end
  endtask

  task automatic test_reset_mid();
    int n, nz;
    ram_clear();
    load_bin(64, 1000);
    mon_clear();
    start_pulse();
    n = 0;
    while (vld_cnt < 40 && n < 2000) begin
      @(posedge clock); n++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dsp_vld !== 1'b0 || busy !== 1'b0 || finish_clear !== 1'b0 || ram_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ctrl: dsp_vld=%b busy=%b finish_clear=%b ram_wr_en=%b, required all 0",
               dsp_vld, busy, finish_clear, ram_wr_en);
    end
    tests++;
    if (N1_u20 !== 20'd0 || N2_u20 !== 20'd0 || GrayAll1 !== 23'd0 || GrayAll2 !== 23'd0) begin
      fails++;
      $display("FAIL rstmid_data: N1=%0d N2=%0d G1=%0d G2=%0d, required all 0",
               N1_u20, N2_u20, GrayAll1, GrayAll2);
    end
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (1500) @(posedge clock);
    #1;
    tests++;
    if (fc_cnt !== 0 || vld_cnt !== 40) begin
      fails++;
      $display("FAIL rstmid_abandon: fc=%0d pulses=%0d, required fc=0 pulses=40", fc_cnt, vld_cnt);
    end
    tests++;
    if (mem[64] !== 20'd1000) begin
      fails++; $display("FAIL rstmid_ram_kept: bin 64 = %0d, required 1000", mem[64]);
    end
    mon_clear();
    start_pulse();
    wait_fc();
    tests++;
    if (vld_cnt !== 128 || fc_cnt !== 1) begin
      fails++;
      $display("FAIL rstmid_refrm: pulses=%0d fc=%0d, required 128 and 1", vld_cnt, fc_cnt);
    end
    tests++;
    if (cap_n1[63] !== 20'd0 || cap_n2[63] !== 20'd1000 || cap_g1[63] !== 23'd0 || cap_g2[63] !== 23'd4000) begin
      fails++;
      $display("FAIL rstmid_t63: got N1=%0d N2=%0d G1=%0d G2=%0d, required 0 1000 0 4000",
               cap_n1[63], cap_n2[63], cap_g1[63], cap_g2[63]);
    end
    tests++;
    if (cap_n1[64] !== 20'd1000 || cap_n2[64] !== 20'd0 || cap_g1[64] !== 23'd4000 || cap_g2[64] !== 23'd0) begin
      fails++;
      $display("FAIL rstmid_t64: got N1=%0d N2=%0d G1=%0d G2=%0d, required 1000 0 4000 0",
               cap_n1[64], cap_n2[64], cap_g1[64], cap_g2[64]);
    end
    nz = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== 20'd0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL rstmid_ram_clear: %0d nonzero bins, required 0", nz);
    end
  endtask

  task automatic test_back_to_back();
    int  n, e1, e2, f1, f2;
    logic seen;
    ram_clear();
    load_bin(20, 100);
    mon_clear();
    start_pulse();
    seen = 1'b0;
    n = 0;
    while (!seen && n < 4000) begin
      @(posedge clock); #1; n++;
      if (finish_clear) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL b2b_wait_fc: no finish_clear within %0d clocks, required one", n);
      return;
    end
    // Start coincident with finish_clear must be ignored.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL b2b_busy_fall: got %b the clock after finish_clear, required 0", busy);
    end
    // Frame 1: bin 20 = 100, gray sum 2000 (>>4 = 125).
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL b2b_f1_count: got %0d, required 128", vld_cnt);
    end
    tests++;
    if (cap_n1[19] !== 20'd0 || cap_n2[19] !== 20'd100 || cap_g1[19] !== 23'd0 || cap_g2[19] !== 23'd125) begin
      fails++;
      $display("FAIL b2b_f1_t19: got N1=%0d N2=%0d G1=%0d G2=%0d, required 0 100 0 125",
               cap_n1[19], cap_n2[19], cap_g1[19], cap_g2[19]);
    end
    tests++;
    if (cap_n1[20] !== 20'd100 || cap_n2[20] !== 20'd0 || cap_g1[20] !== 23'd125 || cap_g2[20] !== 23'd0) begin
      fails++;
      $display("FAIL b2b_f1_t20: got N1=%0d N2=%0d G1=%0d G2=%0d, required 100 0 125 0",
               cap_n1[20], cap_n2[20], cap_g1[20], cap_g2[20]);
    end
    // Frame 2 starts one clock after busy fell; load its bins on the fly.
    mon_clr = 1'b1;
    start = 1'b1; start_cyc = cyc;
    ld_addr = 7'd3; ld_data = 20'd5; ld_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; mon_clr = 1'b0;
    ld_addr = 7'd127; ld_data = 20'd2;
    @(posedge clock); #1;
    ld_en = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL b2b_f2_accept: busy=%b, required 1", busy);
    end
    wait_fc();
    tests++;
    if (vld_cnt !== 128) begin
      fails++; $display("FAIL b2b_f2_count: got %0d, required 128", vld_cnt);
    end
    tests++;
    if (dsp_cyc[0] - start_cyc !== 134) begin
      fails++; $display("FAIL b2b_f2_latency: got %0d, required 134", dsp_cyc[0] - start_cyc);
    end
    // Frame 2 totals: 7 pixels, gray sum 15 + 254 = 269 (>>4 = 16).
    for (int t = 0; t < 128; t++) begin
      if (t < 3)        begin e1 = 0; e2 = 7; f1 = 0;  f2 = 16; end
      else if (t < 127) begin e1 = 5; e2 = 2; f1 = 0;  f2 = 15; end
      else              begin e1 = 7; e2 = 0; f1 = 16; f2 = 0;  end
      tests++;
      if (cap_n1[t] !== 20'(e1) || cap_n2[t] !== 20'(e2) || cap_g1[t] !== 23'(f1) || cap_g2[t] !== 23'(f2)) begin
        fails++;
        $display("FAIL b2b_f2_t%0d: got N1=%0d N2=%0d G1=%0d G2=%0d, required N1=%0d N2=%0d G1=%0d G2=%0d",
                 t, cap_n1[t], cap_n2[t], cap_g1[t], cap_g2[t], e1, e2, f1, f2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_bin64();
    test_two_bins();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
